// File: rtl/keccak_chain_master_if.sv
// keccak_chain_master_if: command, result and accelerator-bus signals of the Keccak chain sequencer.
interface keccak_chain_master_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_secn;
  logic [5:0]   cmd_steps;
  logic         cmd_prf;
  logic [255:0] cmd_seed;
  logic [255:0] cmd_adrs;
  logic [255:0] cmd_msg;
  logic [255:0] cmd_sksd;
  logic         res_valid;
  logic         res_ready;
  logic [255:0] res_data;
  logic         res_err;
  logic         sel;
  logic [3:0]   wen;
  logic [6:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         irq;

  modport master (
    input  cmd_valid, cmd_secn, cmd_steps, cmd_prf, cmd_seed, cmd_adrs, cmd_msg, cmd_sksd,
    input  res_ready, rdata, irq,
    output cmd_ready, res_valid, res_data, res_err, sel, wen, addr, wdata
  );

  modport slave (
    output cmd_valid, cmd_secn, cmd_steps, cmd_prf, cmd_seed, cmd_adrs, cmd_msg, cmd_sksd,
    output res_ready, rdata, irq,
    input  cmd_ready, res_valid, res_data, res_err, sel, wen, addr, wdata
  );
endinterface

// File: rtl/keccak_chain_master.sv
// keccak_chain_master: loads, triggers, waits on and reads back one F/PRF chain on the Keccak accelerator.
// Build option KECC_MASTER_IRQ_EN: completion from the irq pulse instead of status polling.
module keccak_chain_master #(
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned POLL_GAP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  keccak_chain_master_if.master bus
);
  localparam int unsigned CW = 16;
  localparam logic [6:0] A_MSG    = 7'd0;
  localparam logic [6:0] A_ADRS   = 7'd50;
  localparam logic [6:0] A_SEED   = 7'd58;
  localparam logic [6:0] A_SKSD   = 7'd66;
  localparam logic [6:0] A_STATUS = 7'd120;
  localparam logic [6:0] A_SECN   = 7'd122;
  localparam logic [6:0] A_CHNS   = 7'd123;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TRIG, S_WAIT, S_READ, S_RES} state_t;

  state_t          state;
  logic [3:0]      w_q;
  logic [5:0]      steps_q;
  logic            prf_q;
  logic [255:0]    seed_q;
  logic [255:0]    adrs_q;
  logic [255:0]    pay_q;
  logic [4:0]      idx;
  logic [CW-1:0]   tmo_cnt;
`ifndef KECC_MASTER_IRQ_EN
  logic [CW-1:0]   gap_cnt;
  logic            pend;
  logic [CW-1:0]   gap_nxt_c;
`endif

  logic [5:0]      cmd_n_c;
  logic [4:0]      ld_nxt_c;
  logic [2:0]      ld_k;
  logic [6:0]      ld_addr_c;
  logic [31:0]     ld_data_c;
  logic            ld_last_c;
  logic [2:0]      rd_k_c;
  logic            done_c;
  logic            tmo_hit_c;

  function automatic logic [5:0] secn_norm(input logic [7:0] s);
    case (s)
      8'd16:   return 6'd16;
      8'd24:   return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [255:0] trunc(input logic [255:0] d, input logic [3:0] w);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++)
      if (4'(k) < w) r[32*k +: 32] = d[32*k +: 32];
    return r;
  endfunction

  // Next LOAD write: secn, seed[w], adrs[8], then SK.seed or message [w]
  always_comb begin
    cmd_n_c   = secn_norm(bus.cmd_secn);
    ld_nxt_c  = idx + 5'd1;
    ld_last_c = (idx == {w_q, 1'b0} + 5'd8);
    ld_k      = 3'd0;
    ld_addr_c = A_SECN;
    ld_data_c = 32'd0;
    if (ld_nxt_c <= 5'(w_q)) begin
      ld_k      = 3'(ld_nxt_c - 5'd1);
      ld_addr_c = A_SEED + 7'(ld_k);
      ld_data_c = seed_q[{ld_k, 5'd0} +: 32];
    end else if (ld_nxt_c <= 5'(w_q) + 5'd8) begin
      ld_k      = 3'(ld_nxt_c - 5'(w_q) - 5'd1);
      ld_addr_c = A_ADRS + 7'(ld_k);
      ld_data_c = adrs_q[{ld_k, 5'd0} +: 32];
    end else begin
      ld_k      = 3'(ld_nxt_c - 5'(w_q) - 5'd9);
      ld_addr_c = (prf_q ? A_SKSD : A_MSG) + 7'(ld_k);
      ld_data_c = pay_q[{ld_k, 5'd0} +: 32];
    end
  end

  // Completion / timeout detection during WAIT
  always_comb begin
    rd_k_c    = 3'(idx - 5'd1);
    tmo_hit_c = ((tmo_cnt + 16'd1) == CW'(TIMEOUT));
`ifdef KECC_MASTER_IRQ_EN
    done_c    = bus.irq;
`else
    done_c    = pend && (bus.rdata[15:0] == 16'd0);
    gap_nxt_c = (gap_cnt == CW'(POLL_GAP)) ? '0 : gap_cnt + 16'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      bus.cmd_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_err   <= 1'b0;
      bus.res_data  <= '0;
      bus.sel       <= 1'b0;
      bus.wen       <= 4'h0;
      bus.addr      <= 7'd0;
      bus.wdata     <= 32'd0;
      w_q           <= 4'd0;
      steps_q       <= 6'd0;
      prf_q         <= 1'b0;
      seed_q        <= '0;
      adrs_q        <= '0;
      pay_q         <= '0;
      idx           <= 5'd0;
      tmo_cnt       <= '0;
`ifndef KECC_MASTER_IRQ_EN
      gap_cnt       <= '0;
      pend          <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.cmd_valid) begin
          w_q           <= cmd_n_c[5:2];
          steps_q       <= bus.cmd_steps;
          prf_q         <= bus.cmd_prf;
          seed_q        <= bus.cmd_seed;
          adrs_q        <= bus.cmd_adrs;
          pay_q         <= bus.cmd_prf ? bus.cmd_sksd : bus.cmd_msg;
          bus.cmd_ready <= 1'b0;
          bus.res_err   <= 1'b0;
          idx           <= 5'd0;
          if (bus.cmd_steps == 6'd0 && !bus.cmd_prf) begin
            // Zero-length chain: the input is already the result
            state         <= S_RES;
            bus.res_valid <= 1'b1;
            bus.res_data  <= trunc(bus.cmd_msg, cmd_n_c[5:2]);
          end else begin
            state        <= S_LOAD;
            bus.res_data <= '0;
            bus.sel      <= 1'b1;
            bus.wen      <= 4'hF;
            bus.addr     <= A_SECN;
            bus.wdata    <= 32'(cmd_n_c);
          end
        end
        S_LOAD: begin
          if (ld_last_c) begin
            state     <= S_TRIG;
            bus.addr  <= A_CHNS;
            bus.wdata <= {24'd0, 1'b0, prf_q, steps_q};
          end else begin
            idx       <= ld_nxt_c;
            bus.addr  <= ld_addr_c;
            bus.wdata <= ld_data_c;
          end
        end
        S_TRIG: begin
          state     <= S_WAIT;
          tmo_cnt   <= '0;
          bus.wen   <= 4'h0;
          bus.wdata <= 32'd0;
`ifdef KECC_MASTER_IRQ_EN
          bus.sel   <= 1'b0;
`else
          bus.sel   <= 1'b1;
          bus.addr  <= A_STATUS;
          gap_cnt   <= '0;
          pend      <= 1'b0;
`endif
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (done_c) begin
            state    <= S_READ;
            idx      <= 5'd0;
            bus.sel  <= 1'b1;
            bus.addr <= A_MSG;
          end else if (tmo_hit_c) begin
            state         <= S_RES;
            bus.sel       <= 1'b0;
            bus.res_valid <= 1'b1;
            bus.res_err   <= 1'b1;
            bus.res_data  <= '0;
          end else begin
`ifndef KECC_MASTER_IRQ_EN
            pend    <= bus.sel;
            gap_cnt <= gap_nxt_c;
            bus.sel <= (gap_nxt_c == '0);
`endif
          end
        end
        S_READ: begin
          // Word k is issued in READ cycle k and captured in cycle k+1
          if (idx != 5'd0) bus.res_data[{rd_k_c, 5'd0} +: 32] <= bus.rdata;
          if (idx == 5'(w_q)) begin
            state         <= S_RES;
            bus.res_valid <= 1'b1;
            bus.sel       <= 1'b0;
          end else begin
            idx <= ld_nxt_c;
            if (ld_nxt_c < 5'(w_q)) bus.addr <= 7'(ld_nxt_c);
            else                    bus.sel  <= 1'b0;
          end
        end
        S_RES: if (bus.res_ready) begin
          state         <= S_IDLE;
          bus.res_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/keccak_chain_master.md
# keccak_chain_master

Bus-master sequencer that drives the 32-bit memory-mapped Keccak accelerator from the initiator side. It accepts one WOTS/FORS chain command (n, PK.seed, ADRS, message or SK.seed, step count) on a valid/ready port. It then loads the accelerator's register file, triggers the F/PRF chaining operation, waits for completion, and reads back the n-byte result. It sits between the SLH-DSA control FSM and the Keccak accelerator, replacing CPU-driven register pokes.

## Interface
- `TIMEOUT`, default 4096: completion-wait limit in cycles, range 1..65535.
- `POLL_GAP`, default 0: idle cycles inserted between status polls.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high iff state IDLE.
- `cmd_secn`  in  8  n ∈ {16, 24, 32}; any other value is treated as 32.
- `cmd_steps`  in  6  chain length s.
- `cmd_prf`  in  1  prepend PRF (SK.seed → chain start).
- `cmd_seed`  in  256  PK.seed, little-endian (word k = bits [32k+31:32k]).
- `cmd_adrs`  in  256  ADRS.
- `cmd_msg`  in  256  chain input; sent when `cmd_prf`=0.
- `cmd_sksd`  in  256  SK.seed; sent when `cmd_prf`=1.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_data`  out  256  result; bits above 8n are zero.
- `res_err`  out  1  timeout flag, qualified by `res_valid`.
- `sel`  out  1  bus select.
- `wen`  out  4  byte write enables; 4'hF on writes, 0 on reads.
- `addr`  out  7  word address.
- `wdata`  out  32  write data.
- `rdata`  in  32  read data, registered by the slave (valid the cycle after `sel`).
- `irq`  in  1  completion pulse from the slave.

## Operation
- Word count w = n/4 (4, 6 or 8).
- Status register is at address 120; accelerator is busy iff `rdata[15:0]` ≠ 0.
- States: IDLE, LOAD, TRIG, WAIT, READ, RES.
- IDLE: on `cmd_valid`&&`cmd_ready`, latch all command fields and go to LOAD.
  - Bypass case: if `cmd_steps`=0 and `cmd_prf`=0, go straight to RES with `res_data` = `cmd_msg` truncated to 8n bits, `res_err`=0, and no bus activity.
- LOAD: issue one write per cycle in this order:
  - addr 122 ← n;
  - seed words to addr 58..58+w−1;
  - ADRS words to addr 50..57 (always 8 words);
  - SK.seed to addr 66..66+w−1 if `prf`, else message to addr 0..w−1.
  - Total 2w+9 cycles.
- TRIG: one write, addr 123 ← {`prf`, `steps`} as 8'h40|s or 8'h00|s. Then go to WAIT and clear the timeout counter.
- WAIT, polling build (macro undefined):
  - Read addr 120, one poll every POLL_GAP+1 cycles, starting the cycle after TRIG.
  - Check each response one cycle after its request.
  - Exit to READ on the first response with `rdata[15:0]`=0.
- WAIT, irq build (macro defined): `sel`=0; exit to READ on the cycle `irq`=1.
- Timeout: the counter increments every WAIT cycle. When it reaches TIMEOUT, go to RES with `res_err`=1 and `res_data`=0; skip READ.
- READ:
  - Issue reads of addr 0..w−1 on consecutive cycles.
  - The response for word k is captured into `res_data[32k+31:32k]` one cycle after issue.
  - Go to RES after the capture of word w−1.
- RES: `res_valid`=1 and `res_data` held stable. Return to IDLE on `res_ready`=1.
- A new command is accepted no earlier than the cycle after the RES→IDLE transition.
- The master never issues a memory-region access (addr < 120) during WAIT, because such an access would stall the accelerator rounds.
- An `irq` pulse outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `cmd_ready`=1, `res_valid`=0, `res_err`=0, `res_data`=0, `sel`=0, `wen`=0, `addr`=0, `wdata`=0.
- Reset mid-operation: outputs return to their reset values immediately. The accelerator is not reset by this block; the next command's TRIG overwrites CHNS.
- Bus outputs are registered. `sel`/`wen`/`addr`/`wdata` change only on clock edges.
- Cycle count, accept to `res_valid`, excluding the wait:
  - LOAD: 2w+9.
  - TRIG: 1.
  - Wait exit: 1 cycle in irq mode; the response cycle in polling mode.
  - READ: w+1.
- Bypass path: `res_valid` is high the cycle after accept.
- `res_valid` stays high until the handshake. `res_data` does not change while `res_valid`=1.

## Configuration
- `KECC_MASTER_IRQ_EN`:
  - Defined: completion is taken from the `irq` pulse and no status polling occurs.
  - Undefined: completion is taken by polling addr 120 and `irq` is unused.
  - The timeout applies in both builds.

## Test plan
- n=16, s=0, prf=0, msg=0x…0F0E…00 → `res_valid` the cycle after accept; `res_data[127:0]`=msg, upper bits 0; `sel` never asserted.
- n=16, s=1, prf=0, against a cycle-accurate accelerator model → address sequence 122,58..61,50..57,0..3,123 with `wdata`=0x01 at 123; `res_data` equals software SHAKE256 F over 16 bytes.
- n=32, s=5, prf=1 → CHNS write `wdata`=0x45; SK.seed written at 66..73; result matches the reference PRF followed by 5 F iterations; `res_err`=0.
- Bus model holds status nonzero forever, TIMEOUT=100 → `res_valid` with `res_err`=1 and `res_data`=0 after 100 WAIT cycles.
- Assert `rst` low mid-WAIT → all outputs at reset values within the same cycle; a subsequent n=24, s=2 command completes correctly.
- `res_ready` held low for 10 cycles in RES → `res_data` stable and `cmd_ready`=0 throughout; IDLE is entered the cycle after `res_ready`=1.
